// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state, error codes and command record for the APB initiator.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  localparam logic [3:0] ERR_BAD_SEL = 4'hF;
  localparam logic [3:0] ERR_TIMEOUT = 4'hE;

  // Command record widths; the initiator's parameters must not exceed these.
  localparam int APB_SEL_W  = 2;
  localparam int APB_ADDR_W = 2;
  localparam int APB_DATA_W = 8;

  typedef struct packed {
    logic                  write;
    logic [APB_SEL_W-1:0]  sel;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - counts ACCESS wait cycles and flags the cycle on which LIMIT is reached.
module apb_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the wait cycle whose edge brings the count up to LIMIT.
  assign o_expired = i_count_en && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_initiator.sv
// rtl/apb_master_initiator.sv - APB initiator: one SETUP/ACCESS transfer per command, response on valid/ready.
// ACCESS-phase timeout abort is built only when APB_TIMEOUT_EN is defined.
module apb_master_initiator
  import apb_pkg::*;
#(
  parameter int SEL_WIDTH      = 3,
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ERR_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         i_PCLK,
  input  logic                         i_PRESET,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic                         i_cmd_write,
  input  logic [$clog2(SEL_WIDTH)-1:0] i_cmd_sel,
  input  logic [ADDR_WIDTH-1:0]        i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]        i_cmd_wdata,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [DATA_WIDTH-1:0]        o_rsp_rdata,
  output logic [ERR_WIDTH-1:0]         o_rsp_err,
  output logic [SEL_WIDTH-1:0]         o_PSEL,
  output logic                         o_PENABLE,
  output logic                         o_PWRITE,
  output logic [ADDR_WIDTH-1:0]        o_PADDR,
  output logic [DATA_WIDTH-1:0]        o_PWDATA,
  input  logic                         i_PREADY,
  input  logic [DATA_WIDTH-1:0]        i_PRDATA,
  input  logic [ERR_WIDTH-1:0]         i_PSLVERR
);

  localparam int SEL_IDX_W = $clog2(SEL_WIDTH);

  apb_state_t            r_state;
  apb_state_t            w_next_state;
  apb_cmd_t              r_cmd;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ERR_WIDTH-1:0]  r_rsp_err;
  logic                  w_accept;
  logic                  w_bad_sel;
  logic                  w_timeout;

  assign o_rsp_valid = (r_state == RESP);
  assign o_cmd_ready = (r_state == IDLE) && (!o_rsp_valid || i_rsp_ready);
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_bad_sel   = (32'(i_cmd_sel) >= SEL_WIDTH);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_PWRITE    = r_cmd.write;
  assign o_PADDR     = ADDR_WIDTH'(r_cmd.addr);

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_PCLK),
    .i_rst     (i_PRESET),
    .i_clear   (r_state == SETUP),
    .i_count_en((r_state == ACCESS) && !i_PREADY),
    .o_expired (w_timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bus strobes decode from state, so an async reset drops them at once.
  always_comb begin
    w_next_state = r_state;
    o_PSEL       = '0;
    o_PENABLE    = 1'b0;
    o_PWDATA     = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_bad_sel ? RESP : SETUP;
        end
      end
      SETUP: begin
        o_PSEL       = SEL_WIDTH'(1) << SEL_IDX_W'(r_cmd.sel);
        o_PWDATA     = r_cmd.write ? DATA_WIDTH'(r_cmd.wdata) : '0;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        o_PSEL    = SEL_WIDTH'(1) << SEL_IDX_W'(r_cmd.sel);
        o_PENABLE = 1'b1;
        o_PWDATA  = r_cmd.write ? DATA_WIDTH'(r_cmd.wdata) : '0;
        if (i_PREADY || w_timeout) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      r_cmd       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
    end else begin
      if (w_accept) begin
        if (w_bad_sel) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= ERR_WIDTH'(ERR_BAD_SEL);
        end else begin
          r_cmd.write <= i_cmd_write;
          r_cmd.sel   <= APB_SEL_W'(i_cmd_sel);
          r_cmd.addr  <= APB_ADDR_W'(i_cmd_addr);
          r_cmd.wdata <= APB_DATA_W'(i_cmd_wdata);
        end
      end
      if (r_state == ACCESS) begin
        if (i_PREADY) begin
          r_rsp_rdata <= r_cmd.write ? '0 : i_PRDATA;
          r_rsp_err   <= i_PSLVERR;
        end else if (w_timeout) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= ERR_WIDTH'(ERR_TIMEOUT);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_initiator.sv
// tb/tb_apb_master_initiator.sv - randomized self-checking bench for apb_master_initiator.
module tb_apb_master_initiator;

  logic       clk;
  logic       rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       i_cmd_write;
  logic [1:0] i_cmd_sel;
  logic [1:0] i_cmd_addr;
  logic [7:0] i_cmd_wdata;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_rdata;
  logic [3:0] o_rsp_err;
  logic [2:0] o_PSEL;
  logic       o_PENABLE;
  logic       o_PWRITE;
  logic [1:0] o_PADDR;
  logic [7:0] o_PWDATA;
  logic       i_PREADY;
  logic [7:0] i_PRDATA;
  logic [3:0] i_PSLVERR;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_initiator dut (
    .i_PCLK     (clk),
    .i_PRESET   (rst),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_sel  (i_cmd_sel),
    .i_cmd_addr (i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err  (o_rsp_err),
    .o_PSEL     (o_PSEL),
    .o_PENABLE  (o_PENABLE),
    .o_PWRITE   (o_PWRITE),
    .o_PADDR    (o_PADDR),
    .o_PWDATA   (o_PWDATA),
    .i_PREADY   (i_PREADY),
    .i_PRDATA   (i_PRDATA),
    .i_PSLVERR  (i_PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected response {err, rdata}: bad select -> F/0, write -> slave err/0, read -> slave err/data.
  function automatic logic [11:0] model_rsp(input logic wr, input logic [1:0] sel,
                                            input logic [7:0] prdata, input logic [3:0] slverr);
    if (sel >= 2'd3) return {4'hF, 8'h00};
    if (wr) return {slverr, 8'h00};
    return {slverr, prdata};
  endfunction

  task automatic run_cmd(input logic wr, input logic [1:0] sel, input logic [1:0] addr,
                         input logic [7:0] wdata, input int waits, input logic [7:0] prdata,
                         input logic [3:0] slverr, input int rsp_hold);
    logic [11:0] exp;
    logic [2:0]  exp_psel;
    logic [7:0]  exp_pwdata;
    exp        = model_rsp(wr, sel, prdata, slverr);
    exp_psel   = 3'd1 << sel;
    exp_pwdata = wr ? wdata : 8'h00;
    @(negedge clk);
    check("idle_cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_sel   = sel;
    i_cmd_addr  = addr;
    i_cmd_wdata = wdata;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'($urandom);
    i_cmd_sel   = 2'($urandom);
    i_cmd_addr  = 2'($urandom);
    i_cmd_wdata = 8'($urandom);
    if (sel < 2'd3) begin
      check("setup_psel", o_PSEL, exp_psel);
      check("setup_penable", o_PENABLE, 0);
      check("setup_paddr", o_PADDR, addr);
      check("setup_pwrite", o_PWRITE, wr);
      check("setup_pwdata", o_PWDATA, exp_pwdata);
      check("setup_cmd_ready", o_cmd_ready, 0);
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        check("access_penable", o_PENABLE, 1);
        check("access_psel", o_PSEL, exp_psel);
        check("access_paddr", o_PADDR, addr);
        check("access_pwdata", o_PWDATA, exp_pwdata);
        check("access_cmd_ready", o_cmd_ready, 0);
        check("access_rsp_valid", o_rsp_valid, 0);
        i_PREADY  = (i == waits);
        i_PRDATA  = (i == waits) ? prdata : 8'($urandom);
        i_PSLVERR = (i == waits) ? slverr : 4'($urandom);
      end
      @(negedge clk);
      i_PREADY  = 1'b0;
      i_PRDATA  = 8'($urandom);
      i_PSLVERR = 4'($urandom);
    end
    check("rsp_valid", o_rsp_valid, 1);
    check("rsp_rdata", o_rsp_rdata, exp[7:0]);
    check("rsp_err", o_rsp_err, exp[11:8]);
    check("rsp_psel", o_PSEL, 0);
    check("rsp_penable", o_PENABLE, 0);
    check("rsp_pwdata", o_PWDATA, 0);
    check("rsp_cmd_ready", o_cmd_ready, 0);
    for (int h = 0; h < rsp_hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", o_rsp_valid, 1);
      check("hold_rsp_data", {o_rsp_err, o_rsp_rdata}, exp);
      check("hold_cmd_ready", o_cmd_ready, 0);
      check("hold_psel", o_PSEL, 0);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check("done_rsp_valid", o_rsp_valid, 0);
    check("done_cmd_ready", o_cmd_ready, 1);
  endtask

  initial begin
    int n_access;
    rst         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_sel   = 2'd0;
    i_cmd_addr  = 2'd0;
    i_cmd_wdata = 8'h00;
    i_rsp_ready = 1'b0;
    i_PREADY    = 1'b0;
    i_PRDATA    = 8'h00;
    i_PSLVERR   = 4'h0;

    repeat (6) @(negedge clk);
    check("rst_psel", o_PSEL, 0);
    check("rst_penable", o_PENABLE, 0);
    check("rst_pwrite", o_PWRITE, 0);
    check("rst_paddr", o_PADDR, 0);
    check("rst_pwdata", o_PWDATA, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_data", {o_rsp_err, o_rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", o_cmd_ready, 1);
    check("post_rst_rsp_valid", o_rsp_valid, 0);

    run_cmd(1'b1, 2'd0, 2'b01, 8'h1A, 0, 8'hCC, 4'h0, 0);
    run_cmd(1'b0, 2'd0, 2'b00, 8'h55, 3, 8'h34, 4'h0, 5);
    run_cmd(1'b1, 2'd1, 2'b11, 8'h77, 1, 8'h99, 4'b0010, 1);
    run_cmd(1'b0, 2'd2, 2'b10, 8'h00, 0, 8'hA5, 4'h0, 0);
    run_cmd(1'b0, 2'd3, 2'b01, 8'h12, 0, 8'h00, 4'h0, 2);
    run_cmd(1'b1, 2'd3, 2'b10, 8'hFF, 0, 8'h00, 4'h0, 0);

    for (int t = 0; t < 24; t++) begin
      run_cmd(1'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), 8'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)));
    end

    // Reset during ACCESS must drop the strobes immediately and discard the transfer.
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_sel   = 2'd1;
    i_cmd_addr  = 2'd2;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_penable", o_PENABLE, 1);
    check("pre_rst_psel", o_PSEL, 3'b010);
    rst = 1'b1;
    #1;
    check("midrst_psel", o_PSEL, 0);
    check("midrst_penable", o_PENABLE, 0);
    check("midrst_rsp_valid", o_rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_midrst_cmd_ready", o_cmd_ready, 1);
    check("after_midrst_psel", o_PSEL, 0);

    // Slave that never answers.
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_sel   = 2'd0;
    i_cmd_addr  = 2'd1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_PREADY    = 1'b0;
    n_access    = 0;
`ifdef APB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (o_PENABLE) n_access++;
    end
    @(negedge clk);
    check("timeout_access_cycles", n_access, 16);
    check("timeout_rsp_valid", o_rsp_valid, 1);
    check("timeout_rsp_err", o_rsp_err, 4'hE);
    check("timeout_rsp_rdata", o_rsp_rdata, 0);
    check("timeout_psel", o_PSEL, 0);
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check("timeout_done_cmd_ready", o_cmd_ready, 1);
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_PENABLE) n_access++;
    end
    check("hang_access_cycles", n_access, 100);
    check("hang_penable", o_PENABLE, 1);
    check("hang_psel", o_PSEL, 3'b001);
    check("hang_rsp_valid", o_rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("hang_recover_cmd_ready", o_cmd_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_initiator.md
Name: apb_master_initiator

Overview:
- APB initiator (requester side) that drives the execution-unit APB slaves (ALU ops selected by PADDR).
- Takes single commands on a valid/ready request port and runs one APB SETUP/ACCESS transfer per command.
- Returns read data and slave error on a valid/ready response port.
- Sits between the control sequencer and the PSEL-decoded bank of apb_exe_unit slaves; replaces hand-driven bench stimulus in system builds.

Parameters:
- SEL_WIDTH, 3, number of slave select lines (one-hot o_PSEL)
- ADDR_WIDTH, 2, APB address width (ALU opcode at slave)
- DATA_WIDTH, 8, APB data width
- ERR_WIDTH, 4, slave error bus width
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN)

Ports:
- i_PCLK  in  1  clock, all logic on rising edge
- i_PRESET  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid&ready at clock edge
- i_cmd_write  in  1  1=write, 0=read
- i_cmd_sel  in  $clog2(SEL_WIDTH)  target slave index
- i_cmd_addr  in  ADDR_WIDTH  APB address
- i_cmd_wdata  in  DATA_WIDTH  write data
- o_rsp_valid  out  1  response held until accepted
- i_rsp_ready  in  1  response consumer ready
- o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
- o_rsp_err  out  ERR_WIDTH  captured PSLVERR or local error code
- o_PSEL  out  SEL_WIDTH  one-hot slave select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB direction
- o_PADDR  out  ADDR_WIDTH  APB address
- o_PWDATA  out  DATA_WIDTH  APB write data
- i_PREADY  in  1  slave ready
- i_PRDATA  in  DATA_WIDTH  slave read data
- i_PSLVERR  in  ERR_WIDTH  slave error

Behaviour:
- Clock i_PCLK; reset i_PRESET is asynchronous and active-high.
- Reset values (asynchronous, immediate):
  - o_PSEL=0, o_PENABLE=0, o_PWRITE=0, o_PADDR=0, o_PWDATA=0.
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
  - State=IDLE; o_cmd_ready=1 once reset deasserts.
- Reset mid-transfer: o_PSEL/o_PENABLE drop immediately; the transfer and any pending response are discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_cmd_ready = ~o_rsp_valid | i_rsp_ready.
  - On accept with i_cmd_sel < SEL_WIDTH: register cmd fields, go to SETUP.
  - On accept with i_cmd_sel >= SEL_WIDTH: no bus activity; go to RESP with err=4'hF, rdata=0.
- SETUP (exactly 1 cycle):
  - o_PSEL = 1<<sel; o_PADDR/o_PWRITE from cmd; o_PENABLE=0.
  - o_PWDATA = wdata for writes, 0 for reads.
  - Next state ACCESS.
- ACCESS:
  - o_PENABLE=1; all other bus outputs held stable.
  - Stay while i_PREADY=0.
  - On i_PREADY=1 at the edge: capture o_rsp_rdata = i_PRDATA (reads) or 0 (writes), and o_rsp_err = i_PSLVERR.
  - Same edge: o_PSEL, o_PENABLE, o_PWDATA go to 0; state goes to RESP.
- RESP:
  - o_rsp_valid=1; o_rsp_rdata/o_rsp_err stable until i_rsp_ready.
  - When i_rsp_ready=1: clear o_rsp_valid, go to IDLE.
- Throughput: minimum 4 cycles per command (accept, SETUP, ACCESS, RESP).
- o_cmd_ready is 0 in SETUP, ACCESS and RESP.
- Command inputs are ignored after acceptance; changes on them do not disturb the bus.
- o_PENABLE is never 1 while o_PSEL=0. At most one o_PSEL bit is set at any time.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts ACCESS cycles with i_PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, abort: deassert o_PSEL/o_PENABLE and go to RESP with err=4'hE, rdata=0.
  - The counter clears in SETUP.
- Undefined: ACCESS waits indefinitely; no counter logic is present.

Decomposition:
- Package apb_pkg:
  - state enum apb_state_t {IDLE, SETUP, ACCESS, RESP}.
  - Error constants ERR_BAD_SEL=4'hF and ERR_TIMEOUT=4'hE.
  - Command struct apb_cmd_t {write, sel, addr, wdata}.
- Sub-module apb_timeout_counter (counter plus expiry flag), instantiated only under APB_TIMEOUT_EN.

Test Plan:
1. Reset held 6 cycles, then released -> all bus outputs 0, o_cmd_ready=1, o_rsp_valid=0; asserting i_PRESET mid-ACCESS drops o_PSEL=0 within the same timestep.
2. Write sel=0, addr=2'b01, wdata=8'h1A, slave i_PREADY=1 -> SETUP: o_PSEL=3'b001, o_PENABLE=0, o_PADDR=01, o_PWDATA=1A; next cycle o_PENABLE=1; then o_rsp_valid=1, o_rsp_err=0, o_rsp_rdata=0.
3. Read sel=0, addr=00, slave returns i_PRDATA=8'h34 after 3 wait cycles -> ACCESS lasts 4 cycles with bus stable; o_rsp_rdata=8'h34; response held while i_rsp_ready=0 for 5 cycles; o_cmd_ready=0 throughout.
4. Slave returns i_PSLVERR=4'b0010 on a write to addr=2'b11 -> o_rsp_err=4'b0010; read of sel=2 -> o_PSEL=3'b100.
5. i_cmd_sel=3 with SEL_WIDTH=3 -> o_PSEL stays 0 for all cycles; o_rsp_valid=1 next cycle with o_rsp_err=4'hF.
6. APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, i_PREADY held 0 -> abort after 16 ACCESS cycles, o_rsp_err=4'hE; without the macro the bench still sees o_PENABLE=1 at cycle 100.
